// File: rtl/timer_interrupt_unit.sv
// Timer interrupt arbiter: picks the highest-priority pending timer flag, requests the CPU,
// and on acknowledge issues the TIFR flag-clear strobe and the SREG I-bit clear pulse.
module timer_interrupt_unit #(
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic       sysClock,
  input  logic       rst_n,
  input  logic [7:0] TIFR_in,
  input  logic [7:0] TIMSK_in,
  input  logic       global_int_enable,
  input  logic       irq_ack,
  output logic       irq,
  output logic [7:0] irq_vector,
  output logic       TIFR_clear_strobe,
  output logic [7:0] TIFR_clear_mask,
  output logic       clear_global_int
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t     state_r;
  logic [2:0] idx_r;
  logic [3:0] cnt_r;
  logic [7:0] pending_s;
  logic [2:0] winner_s;
  logic       withdraw_s;

  // Highest set bit index; bit7 carries the highest priority.
  function automatic logic [2:0] winner_of(input logic [7:0] p);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin
        w = 3'(i);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Word address of the vector: 0x08 for bit7 down to 0x16 for bit0.
  function automatic logic [7:0] vector_of(input logic [2:0] idx);
    return 8'h08 + {4'd0, 3'd7 - idx, 1'b0};
  endfunction

  assign pending_s  = TIFR_in & TIMSK_in & {8{global_int_enable}};
  assign winner_s   = winner_of(pending_s);
  assign withdraw_s = ~(TIFR_in[idx_r] & TIMSK_in[idx_r] & global_int_enable);

  // Arbitration FSM with registered request and clear-strobe outputs.
  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      idx_r             <= 3'd0;
      cnt_r             <= 4'd0;
      irq               <= 1'b0;
      irq_vector        <= 8'h00;
      TIFR_clear_strobe <= 1'b0;
      TIFR_clear_mask   <= 8'h00;
      clear_global_int  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          TIFR_clear_strobe <= 1'b0;
          TIFR_clear_mask   <= 8'h00;
          clear_global_int  <= 1'b0;
          if (pending_s != 8'h00) begin
            idx_r      <= winner_s;
            irq_vector <= vector_of(winner_s);
            irq        <= 1'b1;
            state_r    <= REQUEST;
          end else begin
            irq     <= 1'b0;
            state_r <= IDLE;
          end
        end
        REQUEST: begin
          // The CPU has committed once it acks, so ack beats a same-edge withdraw.
          if (irq_ack) begin
            irq               <= 1'b0;
            TIFR_clear_strobe <= 1'b1;
            TIFR_clear_mask   <= 8'(8'd1 << idx_r);
            clear_global_int  <= 1'b1;
            state_r           <= CLEAR;
          end else if (withdraw_s) begin
            irq     <= 1'b0;
            state_r <= IDLE;
          end else begin
            irq     <= 1'b1;
            state_r <= REQUEST;
          end
        end
        CLEAR: begin
          irq               <= 1'b0;
          TIFR_clear_strobe <= 1'b0;
          TIFR_clear_mask   <= 8'h00;
          clear_global_int  <= 1'b0;
          cnt_r             <= 4'(HOLDOFF_CYCLES);
          state_r           <= HOLDOFF;
        end
        HOLDOFF: begin
          irq               <= 1'b0;
          TIFR_clear_strobe <= 1'b0;
          TIFR_clear_mask   <= 8'h00;
          clear_global_int  <= 1'b0;
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            state_r <= HOLDOFF;
          end
        end
        default: begin
          irq               <= 1'b0;
          TIFR_clear_strobe <= 1'b0;
          TIFR_clear_mask   <= 8'h00;
          clear_global_int  <= 1'b0;
          cnt_r             <= 4'd0;
          state_r           <= IDLE;
        end
      endcase
    end
  end

endmodule
